// File: rtl/imem_if.sv
// Request/response bus between the core's memory controller and imem_responder.
interface imem_if;
    logic        cs;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        rsp_ack;
    logic        init_done;

    modport master (
        output cs, mem_read, addr, wdata, rsp_ack,
        input  req_ready, rsp_valid, rdata, rsp_err, init_done
    );

    modport slave (
        input  cs, mem_read, addr, wdata, rsp_ack,
        output req_ready, rsp_valid, rdata, rsp_err, init_done
    );
endinterface

// File: rtl/imem_responder.sv
// Word-addressed synchronous RAM responder with programmable access latency
// and a power-up init window; serves one request at a time.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned INIT_CYCLES = 5
) (
    input  logic   clk,
    input  logic   rst,
    imem_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned LAT_W  = $clog2(LATENCY + 1);
    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t            state_q,     state_d;
    logic [INIT_W-1:0] init_cnt_q,  init_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
    req_t              req_q,       req_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              init_done_q, init_done_d;

    logic              mem_we;
    logic [IDX_W-1:0]  req_idx;
    logic              req_bad;

    // Decode the captured address: word index plus alignment/range error.
    always_comb begin
        req_idx = req_q.addr[IDX_W+1:2];
        req_bad = (req_q.addr[1:0] != 2'b00) ||
                  ((req_q.addr >> (IDX_W + 2)) != 32'd0);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        req_d       = req_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        rsp_err_d   = rsp_err_q;
        init_done_d = init_done_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    req_ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                // req_ready is high for the whole IDLE state, so cs alone accepts
                if (bus.cs) begin
                    req_d.rd    = bus.mem_read;
                    req_d.addr  = bus.addr;
                    req_d.wdata = bus.wdata;
                    lat_cnt_d   = LAT_W'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    if (req_bad) begin
                        rsp_err_d = 1'b1;
                        rdata_d   = 32'd0;
                    end else if (req_q.rd) begin
                        rsp_err_d = 1'b0;
                        rdata_d   = mem[req_idx];
                    end else begin
                        rsp_err_d = 1'b0;
                        rdata_d   = 32'd0;
                        mem_we    = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ack) begin
                    rsp_valid_d = 1'b0;
                    rdata_d     = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control/state register; reset discards any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
            init_done_q <= init_done_d;
        end
    end

    // Storage array; intentionally not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_idx] <= req_q.wdata;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed plan steps plus a random
// read/write mix, checked against a word-array reference model.
module tb_imem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT_A = 2;
    localparam int unsigned INIT  = 5;

    logic clk;
    logic rst;

    imem_if m  ();
    imem_if m2 ();

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A), .INIT_CYCLES(INIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .INIT_CYCLES(INIT)) dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (m2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_mem  [int unsigned];
    logic [31:0] ref_mem2 [int unsigned];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= DEPTH * 4);
    endfunction

    // Present one request to the LATENCY=2 responder; returns the model's expected response.
    task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] er, output logic ee);
        int n = 0;
        while (!m.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_req", 32'(m.req_ready), 32'd1);
        m.cs = 1'b1; m.mem_read = rd; m.addr = a; m.wdata = wd;
        @(posedge clk); #1;
        m.cs = 1'b0;
        ee = bad_addr(a);
        er = 32'd0;
        if (!ee) begin
            if (rd) er = ref_mem[a >> 2];
            else    ref_mem[a >> 2] = wd;
        end
    endtask

    // Wait for the response, hold it for 'hold' cycles with noise on cs, then ack it.
    task automatic wait_rsp(input logic [31:0] er, input logic ee, input int hold);
        int lat = 1;
        chk("busy_after_accept", 32'(m.req_ready), 32'd0);
        chk("no_early_valid", 32'(m.rsp_valid), 32'd0);
        while (!m.rsp_valid && lat < 30) begin
            m.cs = 1'($urandom_range(0, 1)); m.addr = $urandom; m.wdata = $urandom;
            m.mem_read = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (!m.rsp_valid) lat++;
        end
        chk("latency", 32'(lat), 32'(LAT_A));
        chk("rdata", m.rdata, er);
        chk("rsp_err", 32'(m.rsp_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            m.cs = 1'($urandom_range(0, 1)); m.addr = $urandom; m.wdata = $urandom;
            m.mem_read = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("hold_valid", 32'(m.rsp_valid), 32'd1);
            chk("hold_rdata", m.rdata, er);
            chk("hold_err", 32'(m.rsp_err), 32'(ee));
            chk("hold_ready", 32'(m.req_ready), 32'd0);
        end
        m.cs = 1'b0;
        m.rsp_ack = 1'b1;
        @(posedge clk); #1;
        m.rsp_ack = 1'b0;
        chk("ack_valid", 32'(m.rsp_valid), 32'd0);
        chk("ack_rdata", m.rdata, 32'd0);
        chk("ack_err", 32'(m.rsp_err), 32'd0);
        chk("ack_ready", 32'(m.req_ready), 32'd1);
    endtask

    logic [31:0] er;
    logic        ee;
    logic [31:0] a;
    logic        rd;
    int          sel;
    int          n;
    logic [31:0] ops_a  [8];
    logic [31:0] ops_wd [8];
    logic        ops_rd [8];
    logic [31:0] exp_q  [$];
    int          acc_c;
    int          nxt;
    int          done;
    bit          accept_now;

    initial begin
        rst = 1'b1;
        m.cs = 1'b1; m.mem_read = 1'b0; m.addr = 32'h0; m.wdata = 32'h1234_5678; m.rsp_ack = 1'b0;
        m2.cs = 1'b0; m2.mem_read = 1'b0; m2.addr = 32'h0; m2.wdata = 32'h0; m2.rsp_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m.rsp_valid), 32'd0);
        chk("rst_rdata", m.rdata, 32'd0);
        chk("rst_err", 32'(m.rsp_err), 32'd0);

        // Step 1: init window with cs held high from cycle 0
        rst = 1'b0;
        for (int k = 0; k < int'(INIT); k++) begin
            chk("init_ready", 32'(m.req_ready), 32'd0);
            chk("init_done_low", 32'(m.init_done), 32'd0);
            @(posedge clk); #1;
        end
        chk("init_done_high", 32'(m.init_done), 32'd1);
        chk("init_ready_high", 32'(m.req_ready), 32'd1);
        issue(1'b0, 32'h0, 32'h1234_5678, er, ee);
        wait_rsp(er, ee, 0);

        // Step 2: write then read back
        issue(1'b0, 32'h40, 32'hDEAD_BEEF, er, ee);
        wait_rsp(er, ee, 0);
        issue(1'b1, 32'h40, 32'h0, er, ee);
        chk("model_rd40", er, 32'hDEAD_BEEF);
        wait_rsp(er, ee, 0);

        // Step 3: misaligned and out-of-range
        issue(1'b1, 32'h42, 32'h0, er, ee);
        chk("model_mis", 32'(ee), 32'd1);
        wait_rsp(er, ee, 0);
        issue(1'b0, 32'h1000, 32'hBAD0_BAD0, er, ee);
        wait_rsp(er, ee, 0);
        issue(1'b1, 32'h0, 32'h0, er, ee);
        wait_rsp(er, ee, 0);

        // Step 4: backpressure
        issue(1'b1, 32'h40, 32'h0, er, ee);
        wait_rsp(er, ee, 7);

        // Step 5: reset one cycle after accepting a read
        issue(1'b1, 32'h40, 32'h0, er, ee);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("midrst_valid", 32'(m.rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int k = 0; k < int'(INIT); k++) begin
            chk("reinit_ready", 32'(m.req_ready), 32'd0);
            chk("reinit_done", 32'(m.init_done), 32'd0);
            chk("reinit_valid", 32'(m.rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("reinit_ready_high", 32'(m.req_ready), 32'd1);
        chk("reinit_valid_idle", 32'(m.rsp_valid), 32'd0);
        issue(1'b1, 32'h40, 32'h0, er, ee);
        wait_rsp(er, ee, 0);

        // Random mix on the LATENCY=2 responder
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 1) a = $urandom | 32'h0000_1000;
            else               a = 32'($urandom_range(0, 31)) << 2;
            rd = 1'($urandom_range(0, 1));
            if (rd && !bad_addr(a) && !ref_mem.exists(a >> 2)) rd = 1'b0;
            issue(rd, a, $urandom, er, ee);
            wait_rsp(er, ee, $urandom_range(0, 3));
        end

        // Step 6: LATENCY=1 responder, ack tied high, cs held high
        n = 0;
        while (!m2.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("l1_ready", 32'(m2.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ops_a[i]      = 32'((i + 4 * $urandom_range(0, 200)) << 2);
            ops_wd[i]     = $urandom;
            ops_rd[i]     = 1'b0;
            ops_a[i + 4]  = ops_a[i];
            ops_wd[i + 4] = 32'h0;
            ops_rd[i + 4] = 1'b1;
        end
        nxt = 0; done = 0; acc_c = -100;
        m2.cs = 1'b1; m2.mem_read = ops_rd[0]; m2.addr = ops_a[0]; m2.wdata = ops_wd[0];
        for (int c = 0; c < 100 && done < 8; c++) begin
            if (m2.rsp_valid) begin
                // ready seen in cycle acc_c; accept edge ends it, response one edge later
                chk("l1_latency", 32'(c - acc_c), 32'd2);
                if (exp_q.size() > 0) chk("l1_rdata", m2.rdata, exp_q.pop_front());
                else chk("l1_spurious", 32'(m2.rsp_valid), 32'd0);
                chk("l1_err", 32'(m2.rsp_err), 32'd0);
                done++;
            end
            accept_now = m2.req_ready && nxt < 8;
            if (accept_now) begin
                if (nxt > 0) chk("l1_spacing", 32'(c - acc_c), 32'd3);
                acc_c = c;
                if (ops_rd[nxt]) exp_q.push_back(ref_mem2[ops_a[nxt] >> 2]);
                else begin
                    exp_q.push_back(32'd0);
                    ref_mem2[ops_a[nxt] >> 2] = ops_wd[nxt];
                end
            end
            @(posedge clk); #1;
            if (accept_now) begin
                nxt++;
                if (nxt < 8) begin
                    m2.mem_read = ops_rd[nxt]; m2.addr = ops_a[nxt]; m2.wdata = ops_wd[nxt];
                end else begin
                    m2.cs = 1'b0;
                end
            end
        end
        chk("l1_count", 32'(done), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
